// File: rtl/shift_exec_stage.sv
// Two-stage shift/rotate unit: S1 captures the request, S2 holds the result
// together with its zero and carry flags, under valid/ready flow control.
module shift_exec_stage (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [1:0] in_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_c,
  output logic       out_zf,
  output logic       out_cf
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  logic       s1_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       s2_free;

  assign s2_free  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_free;

  // Left and right shifts run on 9 bits so the bit shifted out lands in the
  // extra position and doubles as the carry for in-range amounts.
  logic [8:0] l1, l2, l3;
  logic [8:0] r1, r2, r3;
  logic [7:0] t1, t2, t3;
  logic       fill;
  logic       big;
  logic       is_eight;

  assign fill     = (op == OP_SRA) && a[7];
  assign big      = |b[7:3];
  assign is_eight = (b == 8'd8);

  assign l1 = b[2] ? {a[4:0], 4'b0}  : {1'b0, a};
  assign l2 = b[1] ? {l1[6:0], 2'b0} : l1;
  assign l3 = b[0] ? {l2[7:0], 1'b0} : l2;

  assign r1 = b[2] ? {{4{fill}}, a, 1'b0} >> 4 : {a, 1'b0};
  assign r2 = b[1] ? {{2{fill}}, r1[8:2]} : r1;
  assign r3 = b[0] ? {fill, r2[8:1]}      : r2;

  assign t1 = b[2] ? {a[3:0], a[7:4]}   : a;
  assign t2 = b[1] ? {t1[5:0], t1[7:6]} : t1;
  assign t3 = b[0] ? {t2[6:0], t2[7]}   : t2;

  logic [7:0] c_next;
  logic       cf_next;

  always_comb begin
    c_next  = 8'h00;
    cf_next = 1'b0;
    unique case (op)
      OP_SLL: begin
        c_next  = big ? 8'h00 : l3[7:0];
        cf_next = big ? (is_eight && a[0]) : l3[8];
      end
      OP_SRL: begin
        c_next  = big ? 8'h00 : r3[8:1];
        cf_next = big ? (is_eight && a[7]) : r3[0];
      end
      OP_SRA: begin
        c_next  = big ? {8{a[7]}} : r3[8:1];
        cf_next = big ? a[7] : r3[0];
      end
      OP_ROL: begin
        c_next  = t3;
        cf_next = (b[2:0] != 3'd0) && t3[0];
      end
      default: begin
        c_next  = 8'h00;
        cf_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      a         <= 8'h00;
      b         <= 8'h00;
      op        <= 2'b00;
      out_valid <= 1'b0;
      out_c     <= 8'h00;
      out_zf    <= 1'b0;
      out_cf    <= 1'b0;
    end else begin
      if (s1_valid && s2_free) begin
        out_valid <= 1'b1;
        out_c     <= c_next;
        out_zf    <= (c_next == 8'h00);
        out_cf    <= cf_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        a        <= in_a;
        b        <= in_b;
        op       <= in_op;
      end else if (s1_valid && s2_free) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus random
// streams scored against an arithmetic reference model.
module tb_shift_exec_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;
  logic       out_zf;
  logic       out_cf;

  int checks = 0;
  int errors = 0;

  shift_exec_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_zf(out_zf), .out_cf(out_cf)
  );

  always #5 clk = ~clk;

  // Returns {c, zf, cf}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    int n;
    int r;
    logic [7:0] c;
    logic cf;
    n = int'(b);
    c = 8'h00;
    cf = 1'b0;
    case (op)
      2'b00: begin
        c  = (n >= 8) ? 8'h00 : 8'((a << n) & 8'hFF);
        cf = (n == 0 || n > 8) ? 1'b0 : a[8 - n];
      end
      2'b01: begin
        c  = (n >= 8) ? 8'h00 : 8'(a >> n);
        cf = (n == 0 || n > 8) ? 1'b0 : a[n - 1];
      end
      2'b10: begin
        c  = (n >= 8) ? {8{a[7]}} : 8'($signed(a) >>> n);
        cf = (n == 0) ? 1'b0 : (n > 8) ? a[7] : a[n - 1];
      end
      default: begin
        r  = n % 8;
        c  = 8'(((16'(a) << r) | (16'(a) >> (8 - r))) & 16'h00FF);
        cf = (r == 0) ? 1'b0 : c[0];
      end
    endcase
    return {c, (c == 8'h00), cf};
  endfunction

  function automatic logic [7:0] rand_amount();
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 10));
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h96;
    in_b = 8'h01;
    in_op = 2'b00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_c, out_zf, out_cf} !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b c=%h zf=%b cf=%b, want all zero",
               out_valid, out_c, out_zf, out_cf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got out_valid=%b in_ready=%b want 0/1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_directed(input logic [7:0] a, input logic [7:0] b,
                               input logic [1:0] op, input logic [7:0] exp_c,
                               input logic exp_zf, input logic exp_cf,
                               input string name);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_op = op;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: in_ready got %b want 1", name, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid got %b want 0 one edge after accept", name, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, out_c, out_zf, out_cf} !== {1'b1, exp_c, exp_zf, exp_cf}) begin
      errors++;
      $display("FAIL %s: got v=%b c=%h zf=%b cf=%b want v=1 c=%h zf=%b cf=%b",
               name, out_valid, out_c, out_zf, out_cf, exp_c, exp_zf, exp_cf);
    end
    checks++;
    if (model(a, b, op) !== {exp_c, exp_zf, exp_cf}) begin
      errors++;
      $display("FAIL %s_model: model got %h want %h", name, model(a, b, op),
               {exp_c, exp_zf, exp_cf});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_consumed: out_valid got %b want 0", name, out_valid);
    end
  endtask

  // mode 0: out_ready always 1, continuous input
  // mode 1: random out_ready and random input gaps
  // mode 2: out_ready low for the first 5 cycles, then high
  task automatic run_stream(input int n, input int mode, input string name);
    logic [9:0] expq[$];
    logic [9:0] e;
    logic [9:0] held;
    logic was_stall;
    logic acc;
    int sent;
    int got;
    int cyc;
    int win_acc;
    sent = 0; got = 0; cyc = 0; win_acc = 0;
    was_stall = 1'b0;
    held = '0;
    in_valid = 1'b0;
    while ((sent < n || got < n) && cyc < 4000) begin
      @(negedge clk);
      if (was_stall) begin
        checks++;
        if ({out_valid, out_c, out_zf, out_cf} !== {1'b1, held}) begin
          errors++;
          $display("FAIL %s_stall_hold: got v=%b %h want v=1 %h", name, out_valid,
                   {out_c, out_zf, out_cf}, held);
        end
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc >= 5);
      endcase
      if (!in_valid && sent < n && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_a = 8'($urandom);
        in_b = rand_amount();
        in_op = 2'($urandom_range(0, 3));
      end
      #1;
      if (mode == 0 && sent < n) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s_throughput: in_ready got %b want 1 at cycle %0d", name, in_ready, cyc);
        end
      end
      if (mode == 2 && cyc >= 2 && cyc < 5) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_full_stall: in_ready got %b want 0 at cycle %0d", name, in_ready, cyc);
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        expq.push_back(model(in_a, in_b, in_op));
        sent++;
        if (cyc < 5) win_acc++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got unexpected result %h want none", name, {out_c, out_zf, out_cf});
        end else begin
          e = expq.pop_front();
          if ({out_c, out_zf, out_cf} !== e) begin
            errors++;
            $display("FAIL %s_result[%0d]: got c=%h zf=%b cf=%b want c=%h zf=%b cf=%b",
                     name, got, out_c, out_zf, out_cf, e[9:2], e[1], e[0]);
          end
        end
        got++;
      end
      was_stall = out_valid && !out_ready;
      held = {out_c, out_zf, out_cf};
      cyc++;
      @(posedge clk);
      #1;
      if (acc) in_valid = 1'b0;
    end
    checks++;
    if (got != n || sent != n) begin
      errors++;
      $display("FAIL %s_complete: got %0d results of %0d sent, want %0d", name, got, sent, n);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != n + 2) begin
        errors++;
        $display("FAIL %s_cycles: took %0d cycles want %0d", name, cyc, n + 2);
      end
    end
    if (mode == 2) begin
      checks++;
      if (win_acc != 2) begin
        errors++;
        $display("FAIL %s_stall_accepts: got %0d accepts while blocked want 2", name, win_acc);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drained: out_valid got %b want 0", name, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_a = 8'h5A;
    in_b = 8'h03;
    in_op = 2'b11;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_full: got out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_c, out_zf, out_cf} !== 11'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_clear: got v=%b c=%h zf=%b cf=%b rdy=%b want zeros, rdy=1",
               out_valid, out_c, out_zf, out_cf, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_stale[%0d]: out_valid got %b want 0", i, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed(8'h96, 8'h01, 2'b00, 8'h2C, 1'b0, 1'b1, "sll_1");
    test_directed(8'h96, 8'h02, 2'b10, 8'hE5, 1'b0, 1'b1, "sra_2");
    test_directed(8'h96, 8'h09, 2'b01, 8'h00, 1'b1, 1'b0, "srl_9");
    test_directed(8'h81, 8'h08, 2'b00, 8'h00, 1'b1, 1'b1, "sll_8");
    test_directed(8'h80, 8'hFF, 2'b10, 8'hFF, 1'b0, 1'b1, "sra_ff");
    test_directed(8'h96, 8'h0B, 2'b11, 8'hB4, 1'b0, 1'b0, "rol_0b");
    test_directed(8'h96, 8'h00, 2'b01, 8'h96, 1'b0, 1'b0, "srl_0");
    run_stream(16, 0, "back_to_back");
    run_stream(10, 2, "backpressure");
    run_stream(200, 1, "random_ready");
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
